// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register plus direct-mapped instruction cache,
// refilling one whole line over a req/ack handshake on a miss.
module instruction_fetch_unit #(
  parameter int          LINES          = 8,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [63:0] RESET_PC       = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [63:0] pc,
  output logic [31:0] instruction,
  output logic        hit
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 62 - OW - IW;
  typedef enum logic {RUN, REFILL} state_t;
  state_t state, state_next;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] data [LINES][WORDS_PER_LINE];
  logic [61-OW:0] rline;
  logic [OW-1:0] cnt, off;
  logic [IW-1:0] idx, ridx;
  logic [TW-1:0] tag, rtag;
  logic last, fill, start;
  assign idx = pc[2+OW +: IW];
  assign off = pc[2 +: OW];
  assign tag = pc[63 -: TW];
  assign ridx = rline[IW-1:0];
  assign rtag = rline[61-OW -: TW];
  assign last = cnt == OW'(WORDS_PER_LINE - 1);
  assign fill = state == REFILL && mem_ack;
  assign start = state == RUN && state_next == REFILL;
  assign hit = state == RUN && valid[idx] && tags[idx] == tag;
  assign instruction = data[idx][off];
  assign mem_req = state == REFILL;
  // rline is the line-aligned word address, so the word counter just fills the offset field
  assign mem_addr = mem_req ? {rline, cnt, 2'b00} : '0;
  always_comb begin
    state_next = state;
    state_next = state == RUN ? ((!branch_taken && !hit) ? REFILL : RUN)
                              : ((mem_ack && last) ? RUN : REFILL);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc <= RESET_PC;
      valid <= '0;
      cnt <= '0;
      rline <= '0;
    end else begin
      if (branch_taken) pc <= branch_target & ~64'h3;
      else if (hit && !stall) pc <= pc + 64'd4;
      if (start) begin
        rline <= pc[63:2+OW];
        cnt <= '0;
        valid[idx] <= 1'b0;
      end
      if (fill) begin
        cnt <= cnt + OW'(1);
        if (last) valid[ridx] <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (fill) begin
      data[ridx][cnt] <= mem_rdata;
      if (last) tags[ridx] <= rtag;
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table vectors, hand-written corner sequences and random
// traffic checked against a line-address cache model; memory returns data = address.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset_n, stall, branch_taken, mem_ack, mem_req, hit;
  logic [63:0] branch_target, mem_addr, pc;
  logic [31:0] mem_rdata, instruction;
  int errors = 0, checks = 0;
  bit m_valid [8];
  logic [63:0] m_line [8];
  logic [63:0] m_pc, m_base;
  bit m_ref;
  int m_cnt;
  typedef struct {
    bit st; bit bt; logic [63:0] tgt; bit ack;
    logic [63:0] e_pc; bit e_hit; bit e_req; logic [63:0] e_addr;
  } vec_t;
  vec_t tv [10];
  always #5 clk = ~clk;
  instruction_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc), .instruction(instruction),
    .hit(hit)
  );
  function automatic int lidx(input logic [63:0] a);
    return int'((a >> 4) % 64'd8);
  endfunction
  function automatic bit e_hit();
    return !m_ref && m_valid[lidx(m_pc)] && m_line[lidx(m_pc)] == (m_pc & ~64'hF);
  endfunction
  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = 64'h0;
    m_ref = 0;
    m_cnt = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
  endtask
  task automatic model_step(input bit st, input bit bt, input logic [63:0] tgt, input bit ack);
    bit h;
    h = e_hit();
    if (!m_ref) begin
      if (bt) m_pc = tgt & ~64'h3;
      else if (h) begin
        if (!st) m_pc += 64'd4;
      end else begin
        m_ref = 1;
        m_base = m_pc & ~64'hF;
        m_cnt = 0;
        m_valid[lidx(m_pc)] = 0;
      end
    end else begin
      if (bt) m_pc = tgt & ~64'h3;
      if (ack) begin
        m_cnt++;
        if (m_cnt == 4) begin
          m_ref = 0;
          m_valid[lidx(m_base)] = 1;
          m_line[lidx(m_base)] = m_base;
        end
      end
    end
  endtask
  task automatic compare();
    check("pc", pc, m_pc);
    check("hit", 64'(hit), 64'(e_hit()));
    check("mem_req", 64'(mem_req), 64'(m_ref));
    check("mem_addr", mem_addr, m_ref ? m_base + 64'(4 * m_cnt) : 64'h0);
    if (e_hit()) check("instruction", 64'(instruction), m_pc & 64'hFFFF_FFFF);
  endtask
  task automatic step(input bit st, input bit bt, input logic [63:0] tgt, input bit ack);
    stall = st;
    branch_taken = bt;
    branch_target = tgt;
    mem_ack = ack;
    mem_rdata = mem_addr[31:0];
    model_step(st, bt, tgt, ack);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_req", 64'(mem_req), 64'h0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_hit", 64'(hit), 64'h0);
    check("rst_pc", pc, 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    int acks;
    bit a;
    tv[0] = '{0, 0, 64'h0, 1, 64'h0,  0, 1, 64'h0};
    tv[1] = '{0, 0, 64'h0, 1, 64'h0,  0, 1, 64'h4};
    tv[2] = '{0, 0, 64'h0, 1, 64'h0,  0, 1, 64'h8};
    tv[3] = '{0, 0, 64'h0, 1, 64'h0,  0, 1, 64'hC};
    tv[4] = '{0, 0, 64'h0, 1, 64'h0,  1, 0, 64'h0};
    tv[5] = '{0, 0, 64'h0, 1, 64'h4,  1, 0, 64'h0};
    tv[6] = '{0, 0, 64'h0, 1, 64'h8,  1, 0, 64'h0};
    tv[7] = '{0, 0, 64'h0, 1, 64'hC,  1, 0, 64'h0};
    tv[8] = '{0, 0, 64'h0, 1, 64'h10, 0, 0, 64'h0};
    tv[9] = '{0, 0, 64'h0, 0, 64'h10, 0, 1, 64'h10};
    stall = 0; branch_taken = 0; branch_target = 0; mem_ack = 0; mem_rdata = 0;
    do_reset();
    foreach (tv[i]) begin
      step(tv[i].st, tv[i].bt, tv[i].tgt, tv[i].ack);
      check("tv_pc", pc, tv[i].e_pc);
      check("tv_hit", 64'(hit), 64'(tv[i].e_hit));
      check("tv_req", 64'(mem_req), 64'(tv[i].e_req));
      check("tv_addr", mem_addr, tv[i].e_addr);
      if (tv[i].e_hit) check("tv_instr", 64'(instruction), tv[i].e_pc);
    end
    repeat (4) step(0, 0, 0, 1);
    step(0, 1, 64'hC, 0);
    step(0, 1, 64'h8, 0);
    check("loop_pc", pc, 64'h8);
    check("loop_hit", 64'(hit), 64'h1);
    check("loop_req", 64'(mem_req), 64'h0);
    step(0, 1, 64'h80, 0);
    check("conf_miss", 64'(hit), 64'h0);
    repeat (5) step(0, 0, 0, 1);
    check("conf_hit", 64'(hit), 64'h1);
    check("conf_instr", 64'(instruction), 64'h80);
    step(0, 1, 64'h0, 0);
    check("conf_back", 64'(hit), 64'h0);
    acks = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      a = (k % 3 == 2);
      if (a && m_ref) acks++;
      step(0, 0, 0, a);
    end
    check("slow_acks", 64'(acks), 64'h4);
    check("slow_hit", 64'(hit), 64'h1);
    step(0, 1, 64'h40, 0);
    step(0, 0, 0, 0);
    step(0, 1, 64'h101, 1);
    repeat (3) step(0, 0, 0, 1);
    check("br_pc", pc, 64'h100);
    check("br_hit", 64'(hit), 64'h0);
    repeat (5) step(0, 0, 0, 1);
    check("br_refill", 64'(hit), 64'h1);
    check("br_instr", 64'(instruction), 64'h100);
    step(0, 1, 64'h44, 0);
    check("br_line40", 64'(hit), 64'h1);
    step(0, 1, 64'h8, 0);
    repeat (5) step(0, 0, 0, 1);
    repeat (3) begin
      step(1, 0, 0, 0);
      check("stall_pc", pc, 64'h8);
      check("stall_hit", 64'(hit), 64'h1);
    end
    step(0, 0, 0, 0);
    check("stall_rel", pc, 64'hC);
    step(0, 1, 64'h200, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rr_addr", mem_addr, 64'h204);
    do_reset();
    check("rr_pc", pc, 64'h0);
    check("rr_hit", 64'(hit), 64'h0);
    repeat (600)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           64'($urandom_range(0, 'h3FF)), $urandom_range(0, 2) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
